led_pattern_sequencer: RTL and testbench
========================================

Name: led_pattern_sequencer

Overview:
- Controller that sequences the board LED bank: it generates a paced tick and drives one of four animation patterns onto the active-low LED outputs.
- Mode changes arrive over a valid/ready config handshake. They are applied only on tick boundaries so the animations never glitch.
- Sits between board-level control (buttons/host register) and the LED pins; replaces free-running blink logic.

Parameters:
LED_NUM, 35, number of LEDs driven; legal range LED_NUM >= 2
TICK_CYCLES, 1200000, sys_clk cycles per animation step (100 ms at 12 MHz); legal range >= 2
CNT_W, 24, prescaler width; must satisfy 2^CNT_W > TICK_CYCLES

Ports:
sys_clk  input  1  system clock (12 MHz on board)
sys_rst  input  1  reset, asynchronous, active-high
enable  input  1  level; 1 = run animation, 0 = LEDs off
cfg_valid  input  1  config request valid
cfg_ready  output  1  config slot free
cfg_mode  input  2  0 BLINK, 1 CHASE, 2 BOUNCE, 3 FILL
tick_o  output  1  one-cycle pulse, high in the cycle a new pattern first appears
leds  output  LED_NUM  active-low LED drive, equal to ~pattern

Behaviour:
- Reset (async assert, sync release) sets: pattern=0 (leds all 1, all off), cur_mode=BLINK, no pending config, cfg_ready=1, tick_o=0, dir=up, prescaler=0, state=IDLE.
- Prescaler: runs only in RUN and counts 0..TICK_CYCLES-1, then wraps. step = (RUN && cnt==TICK_CYCLES-1). It is forced to 0 outside RUN.
- tick_o is registered and equals step delayed one cycle, aligned with the updated leds.
- FSM states and transitions:
  - IDLE: pattern=0. If enable=1, go to LOAD.
  - LOAD: one cycle. Apply the pending config if any, load the initial pattern of cur_mode, set dir=up, then go to RUN.
  - RUN: on step, advance the pattern, or apply the pending config.
  - From LOAD or RUN, enable=0 goes to IDLE next cycle; pattern cleared, prescaler cleared, pending config kept.
- Latency: enable sampled high at edge k puts the state in LOAD; the initial pattern is visible after edge k+1. The first advance is visible TICK_CYCLES cycles after entering RUN.
- Initial patterns: BLINK=0; CHASE, BOUNCE and FILL = bit0 set.
- Advance rules, per step:
  - BLINK: pattern = ~pattern (all LEDs toggle together).
  - CHASE: rotate left; bit LED_NUM-1 wraps to bit0.
  - BOUNCE: single one moves in direction dir. At bit LED_NUM-1 with dir=up it moves to LED_NUM-2 and dir=down. At bit0 with dir=down it moves to bit1 and dir=up. There is no double-hold at the ends.
  - FILL: if pattern is all-ones it becomes 0; otherwise pattern = (pattern<<1)|1. Period LED_NUM+1 steps.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready. The mode is stored as pending and cfg_ready goes to 0 the next cycle.
  - In IDLE, the pending config is applied in the next cycle: cur_mode updates and pattern stays 0.
  - In LOAD, the pending config is applied as above.
  - In RUN, the pending config is applied at the next step instead of the advance: cur_mode=new, initial pattern of the new mode, dir=up, tick_o pulses. The prescaler is not restarted.
  - cfg_ready returns to 1 the cycle after application.
  - A request equal to cur_mode is still applied, which restarts the pattern.
- Simultaneous events:
  - enable falling on the step cycle: IDLE wins; no advance; pending config kept.
  - cfg transfer on the step cycle: it is not applied at that step; that step advances normally.
- Reset mid-operation: immediate return to reset values; any pending config is discarded.

Decomposition:
- Shared package led_pkg holds:
  - mode constants MODE_BLINK/CHASE/BOUNCE/FILL (2-bit);
  - FSM state encoding ST_IDLE/ST_LOAD/ST_RUN;
  - LED_NUM_DEFAULT=35 and CLK_HZ=12000000.
- One sub-module, led_tick_gen: prescaler with run input and step output, parameterised by TICK_CYCLES/CNT_W.

Test Plan (LED_NUM=4, TICK_CYCLES=4):
- Reset then enable=1, mode BLINK: leds 1111 → pattern toggles every 4 cycles. leds alternates 0000/1111, with tick_o high exactly in the cycle each change appears.
- Config CHASE in IDLE, then enable: patterns 0001, 0010, 0100, 1000, 0001; cfg_ready low for exactly 2 cycles.
- BOUNCE run of 8 steps: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- FILL run: 0001, 0011, 0111, 1111, 0000, 0001. A cfg CHASE accepted mid-run applies at the next step: pattern=0001, prescaler phase unchanged.
- enable drops on the step cycle: leds=1111 next cycle with no advance. A pending cfg survives and is applied in LOAD when enable returns.
- sys_rst asserted asynchronously between clock edges mid-BOUNCE with a cfg pending: leds=1111, cfg_ready=1 and tick_o=0 immediately, without waiting for a clock edge; after release, IDLE with mode BLINK.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants for the LED pattern sequencer: animation modes, FSM state
// encoding and board defaults.
package led_pkg;

  typedef logic [1:0] led_mode_t;

  localparam led_mode_t MODE_BLINK  = 2'd0;
  localparam led_mode_t MODE_CHASE  = 2'd1;
  localparam led_mode_t MODE_BOUNCE = 2'd2;
  localparam led_mode_t MODE_FILL   = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int LED_NUM_DEFAULT = 35;
  localparam int CLK_HZ          = 12000000;

endpackage

// File: rtl/led_tick_gen.sv
// Animation prescaler: counts 0..TICK_CYCLES-1 while run_i is high and flags
// the last count as a step; held at zero whenever run_i is low.
module led_tick_gen #(
  parameter int TICK_CYCLES = 1200000,
  parameter int CNT_W       = 24
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic step_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;

  assign last   = (cnt_q == CNT_W'(TICK_CYCLES - 1));
  assign step_o = run_i && last;

  always_comb begin
    cnt_d = '0;
    if (run_i && !last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED bank controller: paces four animation patterns onto active-low LED pins
// and swaps modes via a valid/ready config slot only on step boundaries.
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int LED_NUM     = LED_NUM_DEFAULT,
  parameter int TICK_CYCLES = 1200000,
  parameter int CNT_W       = 24
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               enable,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_mode,
  output logic               tick_o,
  output logic [LED_NUM-1:0] leds
);

  logic [1:0]         state_q, state_d;
  logic [LED_NUM-1:0] pattern_q, pattern_d;
  led_mode_t          mode_q, mode_d;
  led_mode_t          pend_mode_q, pend_mode_d;
  logic               pend_valid_q, pend_valid_d;
  logic               applied_q, applied_d;
  logic               dir_q, dir_d;
  logic               tick_q;
  logic               step;

  function automatic logic [LED_NUM-1:0] init_pattern(input led_mode_t m);
    init_pattern = (m == MODE_BLINK) ? '0 : {{(LED_NUM-1){1'b0}}, 1'b1};
  endfunction

  led_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES),
    .CNT_W      (CNT_W)
  ) u_tick (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .run_i (state_q == ST_RUN),
    .step_o(step)
  );

  // The slot stays closed one extra cycle after a config is applied.
  assign cfg_ready = !(pend_valid_q || applied_q);
  assign tick_o    = tick_q;
  assign leds      = ~pattern_q;

  always_comb begin
    state_d      = state_q;
    pattern_d    = pattern_q;
    mode_d       = mode_q;
    dir_d        = dir_q;
    pend_valid_d = pend_valid_q;
    pend_mode_d  = pend_mode_q;
    applied_d    = 1'b0;

    if (cfg_valid && cfg_ready) begin
      pend_valid_d = 1'b1;
      pend_mode_d  = cfg_mode;
    end

    case (state_q)
      ST_IDLE: begin
        pattern_d = '0;
        if (pend_valid_q) begin
          mode_d       = pend_mode_q;
          pend_valid_d = 1'b0;
          applied_d    = 1'b1;
        end
        if (enable) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!enable) begin
          state_d   = ST_IDLE;
          pattern_d = '0;
        end else begin
          if (pend_valid_q) begin
            mode_d       = pend_mode_q;
            pattern_d    = init_pattern(pend_mode_q);
            pend_valid_d = 1'b0;
            applied_d    = 1'b1;
          end else begin
            pattern_d = init_pattern(mode_q);
          end
          dir_d   = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d   = ST_IDLE;
          pattern_d = '0;
        end else if (step && pend_valid_q) begin
          mode_d       = pend_mode_q;
          pattern_d    = init_pattern(pend_mode_q);
          dir_d        = 1'b1;
          pend_valid_d = 1'b0;
          applied_d    = 1'b1;
        end else if (step) begin
          case (mode_q)
            MODE_BLINK: pattern_d = ~pattern_q;
            MODE_CHASE: pattern_d = {pattern_q[LED_NUM-2:0], pattern_q[LED_NUM-1]};
            MODE_BOUNCE: begin
              // Reverse on reaching an end so the end LED is lit for one step only.
              if (dir_q) begin
                if (pattern_q[LED_NUM-1]) begin
                  pattern_d = pattern_q >> 1;
                  dir_d     = 1'b0;
                end else begin
                  pattern_d = pattern_q << 1;
                end
              end else begin
                if (pattern_q[0]) begin
                  pattern_d = pattern_q << 1;
                  dir_d     = 1'b1;
                end else begin
                  pattern_d = pattern_q >> 1;
                end
              end
            end
            default: pattern_d = (&pattern_q) ? '0 : {pattern_q[LED_NUM-2:0], 1'b1};
          endcase
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pattern_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      pattern_q    <= '0;
      mode_q       <= MODE_BLINK;
      pend_mode_q  <= MODE_BLINK;
      pend_valid_q <= 1'b0;
      applied_q    <= 1'b0;
      dir_q        <= 1'b1;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      mode_q       <= mode_d;
      pend_mode_q  <= pend_mode_d;
      pend_valid_q <= pend_valid_d;
      applied_q    <= applied_d;
      dir_q        <= dir_d;
      tick_q       <= step;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer (4 LEDs, 4-cycle step) against
// a reference model that derives each pattern from its step index.
module tb_led_pattern_sequencer;

  localparam int NL = 4;
  localparam int TC = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          enable = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [1:0]    cfg_mode = 2'd0;
  logic          cfg_ready;
  logic          tick_o;
  logic [NL-1:0] leds;

  int total = 0;
  int bad = 0;

  // Model: 0 off, 1 loading, 2 animating; mIdx counts steps since the mode started.
  int mPhase = 0;
  int mMode = 0;
  int mIdx = 0;
  int mRunCnt = 0;
  bit mPend = 0;
  int mPendMode = 0;
  bit mJust = 0;
  bit mTick = 0;
  bit stepNow, xfer, justNow;

  led_pattern_sequencer #(
    .LED_NUM    (NL),
    .TICK_CYCLES(TC),
    .CNT_W      (3)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_mode (cfg_mode),
    .tick_o   (tick_o),
    .leds     (leds)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [NL-1:0] patOf(input int mode, input int idx);
    int p, pos, f;
    case (mode)
      0: return (idx % 2 == 1) ? 4'hF : 4'h0;
      1: return 4'(1 << (idx % NL));
      2: begin
        p   = idx % (2 * NL - 2);
        pos = (p < NL) ? p : (2 * NL - 2 - p);
        return 4'(1 << pos);
      end
      default: begin
        f = (idx + 1) % (NL + 1);
        return 4'((1 << f) - 1);
      end
    endcase
  endfunction

  function automatic logic [NL-1:0] modelLeds();
    if (mPhase == 2) return ~patOf(mMode, mIdx);
    return 4'hF;
  endfunction

  function automatic logic modelReady();
    return !(mPend || mJust);
  endfunction

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mPhase = 0; mMode = 0; mIdx = 0; mRunCnt = 0;
      mPend = 0; mPendMode = 0; mJust = 0; mTick = 0;
    end else begin
      stepNow = (mPhase == 2) && (mRunCnt == TC - 1);
      xfer    = cfg_valid && modelReady();
      justNow = 0;
      case (mPhase)
        0: begin
          if (mPend) begin mMode = mPendMode; mPend = 0; justNow = 1; end
          if (enable) mPhase = 1;
        end
        1: begin
          if (!enable) mPhase = 0;
          else begin
            if (mPend) begin mMode = mPendMode; mPend = 0; justNow = 1; end
            mIdx = 0; mRunCnt = 0; mPhase = 2;
          end
        end
        default: begin
          if (!enable) mPhase = 0;
          else begin
            mRunCnt = (mRunCnt + 1) % TC;
            if (stepNow) begin
              if (mPend) begin mMode = mPendMode; mPend = 0; justNow = 1; mIdx = 0; end
              else mIdx++;
            end
          end
        end
      endcase
      if (xfer) begin mPend = 1; mPendMode = int'(cfg_mode); end
      mJust = justNow;
      mTick = stepNow;
    end
  end

  task automatic test_reset();
    #2 sys_rst = 1'b1;
    #1;
    total++; if (leds !== 4'hF) begin bad++; $display("[TB] FAIL reset_leds got=%b want=%b", leds, 4'hF); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", cfg_ready); end
    total++; if (tick_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_tick got=%b want=0", tick_o); end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      enable = 1'b0; cfg_valid = 1'b0;
      @(negedge sys_clk);
      total++; if (leds !== modelLeds()) begin bad++; $display("[TB] FAIL reset_idle_leds c=%0d got=%b want=%b", c, leds, modelLeds()); end
    end
  endtask

  task automatic test_blink();
    for (int c = 0; c < 24; c++) begin
      enable = 1'b1; cfg_valid = 1'b0;
      @(negedge sys_clk);
      total++; if (leds !== modelLeds()) begin bad++; $display("[TB] FAIL blink_leds c=%0d got=%b want=%b", c, leds, modelLeds()); end
      total++; if (tick_o !== mTick) begin bad++; $display("[TB] FAIL blink_tick c=%0d got=%b want=%b", c, tick_o, mTick); end
      total++; if (cfg_ready !== modelReady()) begin bad++; $display("[TB] FAIL blink_ready c=%0d got=%b want=%b", c, cfg_ready, modelReady()); end
    end
  endtask

  task automatic test_chase_cfg_idle();
    int lowCnt = 0;
    for (int c = 0; c < 30; c++) begin
      enable = (c >= 4); cfg_valid = (c == 1); cfg_mode = 2'd1;
      @(negedge sys_clk);
      if (cfg_ready === 1'b0) lowCnt++;
      total++; if (leds !== modelLeds()) begin bad++; $display("[TB] FAIL chase_leds c=%0d got=%b want=%b", c, leds, modelLeds()); end
      total++; if (tick_o !== mTick) begin bad++; $display("[TB] FAIL chase_tick c=%0d got=%b want=%b", c, tick_o, mTick); end
      total++; if (cfg_ready !== modelReady()) begin bad++; $display("[TB] FAIL chase_ready c=%0d got=%b want=%b", c, cfg_ready, modelReady()); end
    end
    total++; if (lowCnt != 2) begin bad++; $display("[TB] FAIL chase_ready_low_cycles got=%0d want=2", lowCnt); end
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 45; c++) begin
      enable = 1'b1; cfg_valid = (c == 0); cfg_mode = 2'd2;
      @(negedge sys_clk);
      total++; if (leds !== modelLeds()) begin bad++; $display("[TB] FAIL bounce_leds c=%0d got=%b want=%b", c, leds, modelLeds()); end
      total++; if (tick_o !== mTick) begin bad++; $display("[TB] FAIL bounce_tick c=%0d got=%b want=%b", c, tick_o, mTick); end
      total++; if (cfg_ready !== modelReady()) begin bad++; $display("[TB] FAIL bounce_ready c=%0d got=%b want=%b", c, cfg_ready, modelReady()); end
    end
  endtask

  task automatic test_fill_then_chase();
    for (int c = 0; c < 50; c++) begin
      enable = 1'b1; cfg_valid = (c == 0) || (c == 30);
      cfg_mode = (c == 0) ? 2'd3 : 2'd1;
      @(negedge sys_clk);
      total++; if (leds !== modelLeds()) begin bad++; $display("[TB] FAIL fill_leds c=%0d got=%b want=%b", c, leds, modelLeds()); end
      total++; if (tick_o !== mTick) begin bad++; $display("[TB] FAIL fill_tick c=%0d got=%b want=%b", c, tick_o, mTick); end
      total++; if (cfg_ready !== modelReady()) begin bad++; $display("[TB] FAIL fill_ready c=%0d got=%b want=%b", c, cfg_ready, modelReady()); end
    end
  endtask

  task automatic test_enable_drop_on_step();
    bit dropped = 0;
    int dropCycle = 0;
    for (int c = 0; c < 40; c++) begin
      cfg_valid = (c == 2); cfg_mode = 2'd3;
      if (!dropped && c > 2 && mPhase == 2 && mRunCnt == TC - 1 && mPend) begin
        dropped = 1; dropCycle = c; enable = 1'b0;
      end else if (dropped && c < dropCycle + 4) begin
        enable = 1'b0;
      end else begin
        enable = 1'b1;
      end
      @(negedge sys_clk);
      total++; if (leds !== modelLeds()) begin bad++; $display("[TB] FAIL drop_leds c=%0d got=%b want=%b", c, leds, modelLeds()); end
      total++; if (cfg_ready !== modelReady()) begin bad++; $display("[TB] FAIL drop_ready c=%0d got=%b want=%b", c, cfg_ready, modelReady()); end
      if (dropped && c == dropCycle) begin
        total++; if (leds !== 4'hF) begin bad++; $display("[TB] FAIL drop_step_leds got=%b want=1111", leds); end
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("[TB] FAIL drop_pending_kept ready=%b want=0", cfg_ready); end
      end
    end
    total++; if (!dropped) begin bad++; $display("[TB] FAIL drop_never_reached_step got=0 want=1"); end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 14; c++) begin
      enable = 1'b1; cfg_valid = (c == 0) || (c == 13);
      cfg_mode = (c == 0) ? 2'd2 : 2'd3;
      @(negedge sys_clk);
      total++; if (leds !== modelLeds()) begin bad++; $display("[TB] FAIL arst_pre_leds c=%0d got=%b want=%b", c, leds, modelLeds()); end
      total++; if (cfg_ready !== modelReady()) begin bad++; $display("[TB] FAIL arst_pre_ready c=%0d got=%b want=%b", c, cfg_ready, modelReady()); end
    end
    cfg_valid = 1'b0;
    #2 sys_rst = 1'b1;
    #1;
    total++; if (leds !== 4'hF) begin bad++; $display("[TB] FAIL arst_leds got=%b want=1111", leds); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("[TB] FAIL arst_ready got=%b want=1", cfg_ready); end
    total++; if (tick_o !== 1'b0) begin bad++; $display("[TB] FAIL arst_tick got=%b want=0", tick_o); end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      enable = 1'b1; cfg_valid = 1'b0;
      @(negedge sys_clk);
      total++; if (leds !== modelLeds()) begin bad++; $display("[TB] FAIL arst_post_leds c=%0d got=%b want=%b", c, leds, modelLeds()); end
      total++; if (tick_o !== mTick) begin bad++; $display("[TB] FAIL arst_post_tick c=%0d got=%b want=%b", c, tick_o, mTick); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      enable    = ($urandom_range(0, 15) != 0);
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_mode  = 2'($urandom_range(0, 3));
      @(negedge sys_clk);
      total++; if (leds !== modelLeds()) begin bad++; $display("[TB] FAIL rand_leds c=%0d got=%b want=%b", c, leds, modelLeds()); end
      total++; if (tick_o !== mTick) begin bad++; $display("[TB] FAIL rand_tick c=%0d got=%b want=%b", c, tick_o, mTick); end
      total++; if (cfg_ready !== modelReady()) begin bad++; $display("[TB] FAIL rand_ready c=%0d got=%b want=%b", c, cfg_ready, modelReady()); end
    end
  endtask

  initial begin
    $display("[TB] led_pattern_sequencer bench start");
    test_reset();
    test_blink();
    test_chase_cfg_idle();
    test_bounce();
    test_fill_then_chase();
    test_enable_drop_on_step();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
